spi_ms_link: RTL and testbench

- Self-contained SPI link: one SPI master and one SPI slave wired back-to-back (SCLK, MOSI, MISO, SS), both in a single clock domain.
- On a start request, the link performs one full-duplex 8-bit exchange, MSB first, in any of the four SPI modes.
- When the transfer completes, the master holds the slave's word and the slave holds the master's word.
- Used as the protocol reference and verification target for SPI mode/edge checking.

---
 rtl/spi_ms_link.sv | 114 +++++++++++
 tb/tb_spi_ms_link.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ms_link.sv
// rtl/spi_ms_link.sv - SPI master and slave wired back-to-back for one full-duplex exchange
// Both ends share one registered sclk/mosi/miso/ss set, so every edge is handled in one process.
module spi_ms_link #(
  parameter int DATA_W   = 8,
  parameter int HALF_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] master_din,
  input  logic [DATA_W-1:0] slave_din,
  output logic [DATA_W-1:0] master_dout,
  output logic [DATA_W-1:0] slave_dout,
  output logic              sclk,
  output logic              mosi,
  output logic              miso,
  output logic              ss,
  output logic              busy,
  output logic              done
);
  localparam int EDGES  = 2 * DATA_W;
  localparam int EDGE_W = $clog2(EDGES + 1);
  localparam int DIV_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(EDGES);
  localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(HALF_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, FINISH} state_t;

  state_t            state;
  logic [EDGE_W-1:0] edge_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic              cpol_q;
  logic              cpha_q;

  logic [EDGE_W-1:0] edge_num;
  logic              div_tick;
  logic              sample_edge;

  // Odd edges are leading; CPHA selects whether the leading or trailing edge samples.
  assign edge_num    = edge_cnt + EDGE_W'(1);
  assign div_tick    = (div_cnt == DIV_MAX);
  assign sample_edge = edge_num[0] ^ cpha_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      edge_cnt    <= '0;
      div_cnt     <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      master_dout <= '0;
      slave_dout  <= '0;
      sclk        <= mode[1];
      mosi        <= 1'b0;
      miso        <= 1'b0;
      ss          <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= mode[1];
          // A start coinciding with the done pulse is deliberately not accepted.
          if (start && !done) begin
            state       <= SETUP;
            cpol_q      <= mode[1];
            cpha_q      <= mode[0];
            master_dout <= master_din;
            slave_dout  <= slave_din;
            mosi        <= master_din[DATA_W-1];
            miso        <= slave_din[DATA_W-1];
            ss          <= 1'b0;
            busy        <= 1'b1;
            edge_cnt    <= '0;
            div_cnt     <= '0;
          end
        end
        SETUP, SHIFT: begin
          if (div_tick) begin
            div_cnt  <= '0;
            edge_cnt <= edge_num;
            sclk     <= ~sclk;
            if (sample_edge) begin
              master_dout <= {master_dout[DATA_W-2:0], miso};
              slave_dout  <= {slave_dout[DATA_W-2:0], mosi};
            end else if (cpha_q || (edge_num != LAST_EDGE)) begin
              mosi <= master_dout[DATA_W-1];
              miso <= slave_dout[DATA_W-1];
            end
            state <= (edge_num == LAST_EDGE) ? FINISH : SHIFT;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        FINISH: begin
          if (div_tick) begin
            state    <= IDLE;
            ss       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            sclk     <= cpol_q;
            div_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_ms_link.sv
// tb/tb_spi_ms_link.sv - table-driven, hand-sequenced and randomized checks of spi_ms_link
module tb_spi_ms_link;
  localparam int W   = 8;
  localparam int H   = 2;
  localparam int LAT = 1 + (2 * W + 1) * H;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] master_din;
  logic [W-1:0] slave_din;
  logic [W-1:0] master_dout;
  logic [W-1:0] slave_dout;
  logic         sclk;
  logic         mosi;
  logic         miso;
  logic         ss;
  logic         busy;
  logic         done;

  spi_ms_link #(.DATA_W(W), .HALF_DIV(H)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .master_din(master_din), .slave_din(slave_din),
    .master_dout(master_dout), .slave_dout(slave_dout),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss(ss),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial-line observer: expected bit stream is the words MSB first, one bit per sample edge.
  logic [1:0]   exp_mode = 2'd0;
  logic [W-1:0] exp_m = '0;
  logic [W-1:0] exp_s = '0;
  int  edge_n = 0, rise_n = 0, samp_n = 0;
  logic p_sclk = 1'b0, p_mosi = 1'b0, p_miso = 1'b0, p_ss = 1'b1;
  bit  leading, is_samp, fall_launch, chg_ok;

  always @(negedge clk) begin
    if (rst === 1'b0 && ss === 1'b0) begin
      if (p_ss) begin
        edge_n = 0;
        rise_n = 0;
        samp_n = 0;
      end else begin
        if (sclk !== p_sclk) begin
          edge_n++;
          if (sclk) rise_n++;
          leading = (edge_n % 2) == 1;
          is_samp = exp_mode[0] ? !leading : leading;
          if (is_samp) begin
            if (samp_n < W) begin
              check("mosi_at_sample", mosi, exp_m[W-1-samp_n]);
              check("miso_at_sample", miso, exp_s[W-1-samp_n]);
            end
            samp_n++;
          end
        end
        if (mosi !== p_mosi || miso !== p_miso) begin
          fall_launch = (exp_mode == 2'd0) || (exp_mode == 2'd3);
          chg_ok = (sclk !== p_sclk) && (sclk == !fall_launch);
          check("data_change_on_launch_edge", chg_ok, 1);
        end
      end
    end
    p_sclk = sclk;
    p_mosi = mosi;
    p_miso = miso;
    p_ss   = ss;
  end

  int c0 = 0;
  int lat = 0;

  task automatic launch(input logic [1:0] m, input logic [W-1:0] md, input logic [W-1:0] sd);
    mode = m; master_din = md; slave_din = sd;
    exp_mode = m; exp_m = md; exp_s = sd;
    start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("ss_low_after_start", ss, 0);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_within_bound", done, 1);
    lat = cyc - c0;
  endtask

  task automatic finish_checks(input logic [W-1:0] emd, input logic [W-1:0] esd);
    check("done_latency", lat, LAT);
    check("ss_high_at_done", ss, 1);
    check("busy_low_at_done", busy, 0);
    check("sclk_idle_cpol", sclk, exp_mode[1]);
    check("master_dout", master_dout, emd);
    check("slave_dout", slave_dout, esd);
    check("rising_edges", rise_n, W);
    check("sample_edges", samp_n, W);
  endtask

  task automatic pulse_check();
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("dout_hold_m", master_dout, exp_s);
    check("dout_hold_s", slave_dout, exp_m);
  endtask

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] md;
    logic [W-1:0] sd;
    logic [W-1:0] exp_mdout;
    logic [W-1:0] exp_sdout;
  } vec_t;
  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, n;
    logic ps;
    bit saw_done;
    logic [1:0] m;
    logic [W-1:0] md, sd;

    vecs[0] = '{2'd0, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[1] = '{2'd1, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[2] = '{2'd2, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[3] = '{2'd3, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[4] = '{2'd0, 8'h01, 8'h80, 8'h80, 8'h01};
    vecs[5] = '{2'd3, 8'h5A, 8'hC3, 8'hC3, 8'h5A};

    rst = 1'b1; start = 1'b0; mode = 2'd2; master_din = 8'h77; slave_din = 8'h99;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss", ss, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mosi", mosi, 0);
    check("rst_miso", miso, 0);
    check("rst_master_dout", master_dout, 0);
    check("rst_slave_dout", slave_dout, 0);
    check("rst_sclk_cpol", sclk, 1);
    rst = 1'b0; mode = 2'd0;
    @(posedge clk); #1;
    check("idle_sclk_follows_mode", sclk, 0);

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].mode, vecs[i].md, vecs[i].sd);
      wait_done();
      finish_checks(vecs[i].exp_mdout, vecs[i].exp_sdout);
      pulse_check();
    end

    // start, master_din and mode disturbed mid-transfer must not affect the exchange
    launch(2'd0, 8'hA5, 8'h3C);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1; master_din = 8'hFF; mode = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    finish_checks(8'h3C, 8'hA5);
    pulse_check();

    // reset after five sclk edges aborts without a done pulse
    launch(2'd0, 8'hA5, 8'h3C);
    cnt = 0; n = 0; ps = sclk;
    while (cnt < 5 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (sclk !== ps) cnt++;
      ps = sclk;
    end
    check("reached_5_edges", cnt, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ss", ss, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_master_dout", master_dout, 0);
    check("abort_slave_dout", slave_dout, 0);
    check("abort_mosi", mosi, 0);
    check("abort_miso", miso, 0);
    saw_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1;
    end
    check("no_done_after_abort", saw_done, 0);
    launch(2'd1, 8'h81, 8'h7E);
    wait_done();
    finish_checks(8'h7E, 8'h81);
    pulse_check();

    // back-to-back: start held through the done cycle is taken one cycle later
    launch(2'd2, 8'h00, 8'hFF);
    wait_done();
    finish_checks(8'hFF, 8'h00);
    start = 1'b1; master_din = 8'hFF; slave_din = 8'h00;
    @(posedge clk); #1;
    check("start_in_done_ignored", ss, 1);
    check("done_one_cycle_b2b", done, 0);
    launch(2'd2, 8'hFF, 8'h00);
    wait_done();
    finish_checks(8'h00, 8'hFF);
    pulse_check();

    for (int i = 0; i < 12; i++) begin
      m  = 2'($urandom_range(0, 3));
      md = W'($urandom);
      sd = W'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      launch(m, md, sd);
      wait_done();
      finish_checks(sd, md);
      pulse_check();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
